// File: rtl/scfifo_multichannel.sv
// Purpose : NUM_CH independent FIFOs sharing one RAM, one write and one read per cycle, each steered by a channel index.
// Latency : read data appears 1 cycle after an accepted rdreq (2 with ADD_RAM_OUTPUT_REG); a written word is readable the next cycle.
// Backpr. : none on the output; writes to a full channel and reads of an empty channel are dropped and flagged (sticky).
//
// Ports
//   clock, aclr_n (async, active low), sclr (sync clear, beats wrreq/rdreq)
//   data/wrreq/wr_chan : write side          rdreq/rd_chan : read side
//   q/q_valid/q_chan   : read data, its strobe and source channel
//   usedw              : per-channel fill count, channel c at [c*(LOG_DEPTH+1) +: LOG_DEPTH+1]
//   empty/full/almost_empty/almost_full : per-channel registered status
//   overflow/underflow : per-channel sticky drop indicators
module scfifo_multichannel #(
    parameter int WIDTH                   = 20,
    parameter int LOG_DEPTH               = 5,
    parameter int NUM_CH                  = 4,
    parameter int LOG_CH                  = 2,
    parameter int ALMOST_FULL_VALUE       = 30,
    parameter int ALMOST_EMPTY_VALUE      = 2,
    parameter int ADD_RAM_OUTPUT_REG      = 0,
    parameter int ALLOW_RWCYCLE_WHEN_FULL = 0
) (
    input  logic                            clock,
    input  logic                            aclr_n,
    input  logic                            sclr,
    input  logic [WIDTH-1:0]                data,
    input  logic                            wrreq,
    input  logic [LOG_CH-1:0]               wr_chan,
    input  logic                            rdreq,
    input  logic [LOG_CH-1:0]               rd_chan,
    output logic [WIDTH-1:0]                q,
    output logic                            q_valid,
    output logic [LOG_CH-1:0]               q_chan,
    output logic [NUM_CH*(LOG_DEPTH+1)-1:0] usedw,
    output logic [NUM_CH-1:0]               empty,
    output logic [NUM_CH-1:0]               full,
    output logic [NUM_CH-1:0]               almost_empty,
    output logic [NUM_CH-1:0]               almost_full,
    output logic [NUM_CH-1:0]               overflow,
    output logic [NUM_CH-1:0]               underflow
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int UW    = LOG_DEPTH + 1;
    localparam int AW    = LOG_CH + LOG_DEPTH;

    localparam logic [UW-1:0] CNT_FULL = UW'(DEPTH);
    localparam logic [UW-1:0] AF_TH    = UW'(ALMOST_FULL_VALUE);
    localparam logic [UW-1:0] AE_TH    = UW'(ALMOST_EMPTY_VALUE);
    localparam logic          RW_FULL  = (ALLOW_RWCYCLE_WHEN_FULL != 0);
    localparam logic          AE_RST   = (ALMOST_EMPTY_VALUE > 0);

    // Per-channel state
    logic [LOG_DEPTH-1:0] wr_ptr_q [NUM_CH];
    logic [LOG_DEPTH-1:0] wr_ptr_d [NUM_CH];
    logic [LOG_DEPTH-1:0] rd_ptr_q [NUM_CH];
    logic [LOG_DEPTH-1:0] rd_ptr_d [NUM_CH];
    logic [UW-1:0]        usedw_q  [NUM_CH];
    logic [UW-1:0]        usedw_d  [NUM_CH];

    logic [NUM_CH-1:0] empty_q, empty_d;
    logic [NUM_CH-1:0] full_q, full_d;
    logic [NUM_CH-1:0] aempty_q, aempty_d;
    logic [NUM_CH-1:0] afull_q, afull_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] unf_q, unf_d;

    // Shared storage, channel index forms the upper address bits
    logic [WIDTH-1:0] mem_q [NUM_CH*DEPTH];

    logic          rd_acc;
    logic          wr_acc;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // Read stage directly behind the RAM
    logic              s1_vld_q;
    logic [WIDTH-1:0]  s1_dat_q;
    logic [LOG_CH-1:0] s1_chan_q;

    // sclr suppresses both accepts so the RAM and pointers stay untouched by a clearing cycle.
    // A full channel may still take a write when the same channel is popped in that cycle.
    always_comb begin
        rd_acc  = rdreq & ~sclr & ~empty_q[rd_chan];
        wr_acc  = wrreq & ~sclr &
                  (~full_q[wr_chan] | (RW_FULL & rd_acc & (rd_chan == wr_chan)));
        wr_addr = {wr_chan, wr_ptr_q[wr_chan]};
        rd_addr = {rd_chan, rd_ptr_q[rd_chan]};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        empty_d  = empty_q;
        full_d   = full_q;
        aempty_d = aempty_q;
        afull_d  = afull_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (sclr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                usedw_d[c]  = '0;
            end
            empty_d  = '1;
            full_d   = '0;
            aempty_d = {NUM_CH{AE_RST}};
            afull_d  = '0;
            ovf_d    = '0;
            unf_d    = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_acc && (wr_chan == LOG_CH'(c))) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
                if (rd_acc && (rd_chan == LOG_CH'(c))) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                // Same-channel push and pop cancel out
                case ({wr_acc && (wr_chan == LOG_CH'(c)), rd_acc && (rd_chan == LOG_CH'(c))})
                    2'b10:   usedw_d[c] = usedw_q[c] + 1'b1;
                    2'b01:   usedw_d[c] = usedw_q[c] - 1'b1;
                    default: usedw_d[c] = usedw_q[c];
                endcase
                if (wrreq && !wr_acc && (wr_chan == LOG_CH'(c))) begin
                    ovf_d[c] = 1'b1;
                end
                if (rdreq && !rd_acc && (rd_chan == LOG_CH'(c))) begin
                    unf_d[c] = 1'b1;
                end
                // Flags come from the next count so they are correct right after the edge
                empty_d[c]  = (usedw_d[c] == '0);
                full_d[c]   = (usedw_d[c] == CNT_FULL);
                aempty_d[c] = (usedw_d[c] < AE_TH);
                afull_d[c]  = (usedw_d[c] >= AF_TH);
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            usedw_q  <= '{default: '0};
            empty_q  <= '1;
            full_q   <= '0;
            aempty_q <= {NUM_CH{AE_RST}};
            afull_q  <= '0;
            ovf_q    <= '0;
            unf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // RAM write port; not reset, contents survive clears
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= data;
        end
    end

    // Read register. A full channel written and read in one cycle hits the same address;
    // the non-blocking write makes the read return the old (oldest queued) word, as required.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_chan_q <= '0;
        end else if (sclr) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_chan_q <= '0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
                s1_dat_q  <= mem_q[rd_addr];
                s1_chan_q <= rd_chan;
            end
        end
    end

    generate
        if (ADD_RAM_OUTPUT_REG != 0) begin : g_out_reg
            logic              s2_vld_q;
            logic [WIDTH-1:0]  s2_dat_q;
            logic [LOG_CH-1:0] s2_chan_q;

            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n) begin
                    s2_vld_q  <= 1'b0;
                    s2_dat_q  <= '0;
                    s2_chan_q <= '0;
                end else if (sclr) begin
                    s2_vld_q  <= 1'b0;
                    s2_dat_q  <= '0;
                    s2_chan_q <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_dat_q  <= s1_dat_q;
                        s2_chan_q <= s1_chan_q;
                    end
                end
            end

            assign q       = s2_dat_q;
            assign q_valid = s2_vld_q;
            assign q_chan  = s2_chan_q;
        end else begin : g_no_out_reg
            assign q       = s1_dat_q;
            assign q_valid = s1_vld_q;
            assign q_chan  = s1_chan_q;
        end
    endgenerate

    for (genvar c = 0; c < NUM_CH; c++) begin : g_usedw
        assign usedw[c*UW +: UW] = usedw_q[c];
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_scfifo_multichannel.sv
// Two instances share one stimulus stream: "a" with default parameters, "b" with the
// full-channel read/write cycle allowed and the extra output register. Each is compared
// every cycle against per-channel reference queues.
module tb_scfifo_multichannel;

    localparam int W     = 20;
    localparam int NC    = 4;
    localparam int LC    = 2;
    localparam int DEPTH = 32;
    localparam int UW    = 6;

    logic          clock   = 1'b0;
    logic          aclr_n  = 1'b0;
    logic          sclr    = 1'b0;
    logic [W-1:0]  data    = '0;
    logic          wrreq   = 1'b0;
    logic [LC-1:0] wr_chan = '0;
    logic          rdreq   = 1'b0;
    logic [LC-1:0] rd_chan = '0;

    logic [W-1:0]     q_a, q_b;
    logic             qv_a, qv_b;
    logic [LC-1:0]    qc_a, qc_b;
    logic [NC*UW-1:0] uw_a, uw_b;
    logic [NC-1:0]    em_a, em_b, fu_a, fu_b, ae_a, ae_b, af_a, af_b;
    logic [NC-1:0]    ov_a, ov_b, un_a, un_b;

    always #5 clock = ~clock;

    scfifo_multichannel #(
        .WIDTH(W), .LOG_DEPTH(5), .NUM_CH(NC), .LOG_CH(LC),
        .ALMOST_FULL_VALUE(30), .ALMOST_EMPTY_VALUE(2),
        .ADD_RAM_OUTPUT_REG(0), .ALLOW_RWCYCLE_WHEN_FULL(0)
    ) dut_a (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq),
        .wr_chan(wr_chan), .rdreq(rdreq), .rd_chan(rd_chan), .q(q_a), .q_valid(qv_a),
        .q_chan(qc_a), .usedw(uw_a), .empty(em_a), .full(fu_a), .almost_empty(ae_a),
        .almost_full(af_a), .overflow(ov_a), .underflow(un_a)
    );

    scfifo_multichannel #(
        .WIDTH(W), .LOG_DEPTH(5), .NUM_CH(NC), .LOG_CH(LC),
        .ALMOST_FULL_VALUE(30), .ALMOST_EMPTY_VALUE(2),
        .ADD_RAM_OUTPUT_REG(1), .ALLOW_RWCYCLE_WHEN_FULL(1)
    ) dut_b (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq),
        .wr_chan(wr_chan), .rdreq(rdreq), .rd_chan(rd_chan), .q(q_b), .q_valid(qv_b),
        .q_chan(qc_b), .usedw(uw_b), .empty(em_b), .full(fu_b), .almost_empty(ae_b),
        .almost_full(af_b), .overflow(ov_b), .underflow(un_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one queue per (instance, channel), index = inst*NC + chan
    logic [W-1:0]  mq [2*NC][$];
    logic [NC-1:0] m_ov [2];
    logic [NC-1:0] m_un [2];
    logic          pend_v [2];   // word read last cycle, still on its way out (instance b only)
    logic [W-1:0]  pend_d [2];
    logic [LC-1:0] pend_c [2];
    logic          e_v [2];
    logic [W-1:0]  e_q [2];
    logic [LC-1:0] e_c [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        for (int c = 0; c < NC; c++) mq[i*NC+c].delete();
        m_ov[i]   = '0;
        m_un[i]   = '0;
        pend_v[i] = 1'b0;
        pend_d[i] = '0;
        pend_c[i] = '0;
        e_v[i]    = 1'b0;
        e_q[i]    = '0;
        e_c[i]    = '0;
    endtask

    // Effect of one clock edge on instance i. Instance 1 allows write-to-full with a
    // same-channel read, and delivers read data one cycle later than instance 0.
    task automatic model_step(input int i, input logic wr, input logic [LC-1:0] wc,
                              input logic [W-1:0] d, input logic rd, input logic [LC-1:0] rc,
                              input logic sc);
        int           b = i * NC;
        logic         racc;
        logic         wacc;
        logic [W-1:0] rdat = '0;
        if (sc) begin
            model_reset(i);
        end else begin
            racc = rd && (mq[b+int'(rc)].size() > 0);
            wacc = wr && ((mq[b+int'(wc)].size() < DEPTH) || (i == 1 && racc && rc == wc));
            if (rd && !racc) m_un[i][rc] = 1'b1;
            if (wr && !wacc) m_ov[i][wc] = 1'b1;
            if (racc) rdat = mq[b+int'(rc)].pop_front();
            if (wacc) mq[b+int'(wc)].push_back(d);
            if (i == 1) begin
                e_v[i] = pend_v[i];
                if (pend_v[i]) begin
                    e_q[i] = pend_d[i];
                    e_c[i] = pend_c[i];
                end
                pend_v[i] = racc;
                pend_d[i] = rdat;
                pend_c[i] = rc;
            end else begin
                e_v[i] = racc;
                if (racc) begin
                    e_q[i] = rdat;
                    e_c[i] = rc;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [W-1:0] oq, input logic oqv,
                              input logic [LC-1:0] oqc, input logic [NC*UW-1:0] ouw,
                              input logic [NC-1:0] oem, input logic [NC-1:0] ofu,
                              input logic [NC-1:0] oae, input logic [NC-1:0] oaf,
                              input logic [NC-1:0] oov, input logic [NC-1:0] oun);
        string            p = (i == 0) ? "a" : "b";
        logic [NC*UW-1:0] euw;
        logic [NC-1:0]    eem, efu, eae, eaf;
        for (int c = 0; c < NC; c++) begin
            int n = mq[i*NC+c].size();
            euw[c*UW +: UW] = UW'(n);
            eem[c] = (n == 0);
            efu[c] = (n == DEPTH);
            eae[c] = (n < 2);
            eaf[c] = (n >= 30);
        end
        chk({p, "_q_valid"},      32'(oqv), 32'(e_v[i]));
        chk({p, "_q"},            32'(oq),  32'(e_q[i]));
        chk({p, "_q_chan"},       32'(oqc), 32'(e_c[i]));
        chk({p, "_usedw"},        32'(ouw), 32'(euw));
        chk({p, "_empty"},        32'(oem), 32'(eem));
        chk({p, "_full"},         32'(ofu), 32'(efu));
        chk({p, "_almost_empty"}, 32'(oae), 32'(eae));
        chk({p, "_almost_full"},  32'(oaf), 32'(eaf));
        chk({p, "_overflow"},     32'(oov), 32'(m_ov[i]));
        chk({p, "_underflow"},    32'(oun), 32'(m_un[i]));
    endtask

    task automatic check_both();
        check_inst(0, q_a, qv_a, qc_a, uw_a, em_a, fu_a, ae_a, af_a, ov_a, un_a);
        check_inst(1, q_b, qv_b, qc_b, uw_b, em_b, fu_b, ae_b, af_b, ov_b, un_b);
    endtask

    // Drive one cycle of stimulus, advance past the edge, then compare both instances
    task automatic cyc(input logic wr, input logic [LC-1:0] wc, input logic [W-1:0] d,
                       input logic rd, input logic [LC-1:0] rc, input logic sc);
        wrreq   = wr;
        wr_chan = wc;
        data    = d;
        rdreq   = rd;
        rd_chan = rc;
        sclr    = sc;
        model_step(0, wr, wc, d, rd, rc, sc);
        model_step(1, wr, wc, d, rd, rc, sc);
        @(posedge clock);
        #1;
        check_both();
        wrreq = 1'b0;
        rdreq = 1'b0;
        sclr  = 1'b0;
    endtask

    logic [LC-1:0] rch  [5] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [W-1:0]  rexp [5] = '{20'd20, 20'd10, 20'd21, 20'd11, 20'd12};

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset state
        #12;
        aclr_n = 1'b1;
        check_both();
        chk("rst_empty", 32'(em_a), 32'hF);
        chk("rst_almost_empty", 32'(ae_b), 32'hF);
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);

        // Fill channel 2 with 0..31, then one write too many
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, 2'd2, W'(k), 1'b0, 2'd0, 1'b0);
            if (k == 28) chk("fill_af_29", 32'(af_a[2]), 32'd0);
            if (k == 29) chk("fill_af_30", 32'(af_a[2]), 32'd1);
        end
        chk("fill_usedw2", 32'(uw_a[2*UW +: UW]), 32'd32);
        chk("fill_full", 32'(fu_a), 32'h4);
        chk("fill_empty", 32'(em_a), 32'hB);
        cyc(1'b1, 2'd2, 20'd99, 1'b0, 2'd0, 1'b0);
        chk("fill_overflow", 32'(ov_a), 32'h4);
        chk("fill_usedw2_after", 32'(uw_b[2*UW +: UW]), 32'd32);

        // Interleaved channels
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        chk("sclr_overflow", 32'(ov_a), 32'd0);
        cyc(1'b1, 2'd0, 20'd10, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd3, 20'd20, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 20'd11, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd3, 20'd21, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 20'd12, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 2'd0, '0, 1'b1, rch[k], 1'b0);
            chk("ilv_a_q", 32'(q_a), 32'(rexp[k]));
            chk("ilv_a_chan", 32'(qc_a), 32'(rch[k]));
            chk("ilv_b_valid", 32'(qv_b), (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk("ilv_b_q", 32'(q_b), 32'(rexp[k-1]));
        end
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        chk("ilv_b_last", 32'(q_b), 32'd12);
        chk("ilv_a_hold", 32'(q_a), 32'd12);

        // Full channel 1: simultaneous write and read
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, 2'd1, W'(100 + k), 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 20'd99, 1'b1, 2'd1, 1'b0);
        chk("rw_a_overflow", 32'(ov_a[1]), 32'd1);
        chk("rw_a_usedw1", 32'(uw_a[UW +: UW]), 32'd31);
        chk("rw_b_overflow", 32'(ov_b[1]), 32'd0);
        chk("rw_b_usedw1", 32'(uw_b[UW +: UW]), 32'd32);
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        chk("rw_b_q", 32'(q_b), 32'd100);

        // Write then read next cycle; underflow on empty channel 0
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 20'd55, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0);
        chk("vis_a_q", 32'(q_a), 32'd55);
        cyc(1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);
        chk("udf_a", 32'(un_a), 32'h1);
        chk("udf_a_valid", 32'(qv_a), 32'd0);
        chk("vis_b_q", 32'(q_b), 32'd55);

        // Asynchronous reset with a read still in flight
        cyc(1'b1, 2'd0, 20'd5, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd3, 20'd6, 1'b1, 2'd0, 1'b0);
        aclr_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_both();
        chk("aclr_a_empty", 32'(em_a), 32'hF);
        chk("aclr_b_usedw", 32'(uw_b), 32'd0);
        #1;
        aclr_n = 1'b1;
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        chk("aclr_b_pending", 32'(qv_b), 32'd0);

        // Random traffic, alternating write-heavy and read-heavy phases
        for (int n = 0; n < 10000; n++) begin
            int            wthr = ((n / 700) % 2 == 0) ? 70 : 30;
            logic          wr   = ($urandom_range(99) < wthr);
            logic          rd   = ($urandom_range(99) < (100 - wthr));
            logic [LC-1:0] wc   = LC'($urandom);
            logic [LC-1:0] rc   = LC'($urandom);
            logic          sc   = ($urandom_range(599) == 0);
            if ($urandom_range(3) == 0) rc = wc;
            cyc(wr, wc, W'($urandom), rd, rc, sc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
